// File: rtl/hdmi_pixel_feeder.sv
// Show-ahead pixel FIFO between the SDRAM read path and the HDMI timing driver.
// Zero-latency head on lcd_data; s_ready deasserts when full, during reset and on frame flush.
module hdmi_pixel_feeder #(
  parameter int          DEPTH     = 1024,
  parameter int          AW        = 10,
  parameter int          BURST_LEN = 256,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [15:0] UF_COLOR  = 16'hF800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          lcd_request,
  input  logic          first_ack,
  input  logic          lcd_vs,
  output logic [15:0]   lcd_data,
  output logic          frame_start,
  output logic          burst_req,
  output logic [AW:0]   fifo_level,
  output logic          underflow,
  output logic [15:0]   underflow_cnt
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_ROOM = (AW+1)'(DEPTH - BURST_LEN);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          vs_d;
  logic          vs_rise;
  logic          want;
  logic          empty;
  logic          push;
  logic          pop;

  assign vs_rise = lcd_vs & ~vs_d;
  assign want    = lcd_request & first_ack;
  assign empty   = (count == '0);
  assign s_ready = (count < FULL_LEVEL) & ~frame_start & ~rst;
  assign push    = s_valid & s_ready;
  // A flush cycle ignores pops as well as pushes.
  assign pop     = want & ~empty & ~frame_start;

  always_comb begin
    count_next = count;
    if (rst || frame_start) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
    end
  end

  always_comb begin
    lcd_data = BG_COLOR;
    if (want) lcd_data = empty ? UF_COLOR : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d        <= 1'b0;
      frame_start <= 1'b0;
      burst_req   <= 1'b0;
    end else begin
      vs_d        <= lcd_vs;
      frame_start <= vs_rise;
      burst_req   <= (count_next <= BURST_ROOM) & ~vs_rise & ~frame_start;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Underflow statistics are per frame, so the flush clears them too.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else if (want && empty) begin
      underflow <= 1'b1;
      if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

  assign fifo_level = count;

endmodule

// File: tb/tb_hdmi_pixel_feeder.sv
// Randomized bench for hdmi_pixel_feeder against a queue-based reference model.
module tb_hdmi_pixel_feeder;

  localparam int DEPTH     = 1024;
  localparam int AW        = 10;
  localparam int BURST_LEN = 256;
  localparam logic [15:0] BG = 16'h0000;
  localparam logic [15:0] UF = 16'hF800;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        lcd_request;
  logic        first_ack;
  logic        lcd_vs;
  logic [15:0] lcd_data;
  logic        frame_start;
  logic        burst_req;
  logic [AW:0] fifo_level;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic        m_uf;
  logic [15:0] m_ufc;
  logic        m_fs;
  logic        m_vs_d;
  logic        m_br;

  always #5 clk = ~clk;

  hdmi_pixel_feeder #(
    .DEPTH(DEPTH), .AW(AW), .BURST_LEN(BURST_LEN), .BG_COLOR(BG), .UF_COLOR(UF)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .lcd_request(lcd_request), .first_ack(first_ack), .lcd_vs(lcd_vs),
    .lcd_data(lcd_data), .frame_start(frame_start), .burst_req(burst_req),
    .fifo_level(fifo_level), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  function automatic logic [15:0] exp_lcd();
    if (lcd_request && first_ack) return (mq.size() != 0) ? mq[0] : UF;
    return BG;
  endfunction

  function automatic logic exp_ready();
    return !rst && !m_fs && (mq.size() < DEPTH);
  endfunction

  // Advance the model by one clock using the inputs currently applied, then clock the DUT.
  task automatic cyc();
    bit want, was_empty, push, pop, vs_rise;
    want      = lcd_request && first_ack;
    was_empty = (mq.size() == 0);
    push      = s_valid && exp_ready();
    pop       = want && !was_empty && !m_fs;
    vs_rise   = lcd_vs && !m_vs_d;
    if (rst) begin
      mq.delete(); m_uf = 0; m_ufc = 0; m_fs = 0; m_vs_d = 0; m_br = 0;
    end else begin
      if (m_fs) begin
        mq.delete(); m_uf = 0; m_ufc = 0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(s_data);
        if (want && was_empty) begin
          m_uf = 1;
          if (m_ufc != 16'hFFFF) m_ufc = m_ufc + 16'd1;
        end
      end
      m_br   = (mq.size() <= DEPTH - BURST_LEN) && !vs_rise && !m_fs;
      m_fs   = vs_rise;
      m_vs_d = lcd_vs;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = 0; s_data = '0; lcd_request = 0; first_ack = 0;
  endtask

  task automatic start_frame();
    idle_inputs();
    lcd_vs = 0; cyc();
    lcd_vs = 1; cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1; lcd_vs = 0; idle_inputs();
    #1;
    n_vec++;
    if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got %b want 0", s_ready); end
    cyc(); cyc();
    rst = 0; lcd_vs = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      n_vec++;
      if (frame_start !== (c == 2)) begin
        n_err++; $display("FAIL reset_frame_start cycle %0d got %b want %b", c, frame_start, c == 2);
      end
      n_vec++;
      if (fifo_level !== '0 || underflow !== 1'b0 || underflow_cnt !== 16'd0) begin
        n_err++; $display("FAIL reset_state cycle %0d level %0d uf %b cnt %0d want 0/0/0", c, fifo_level, underflow, underflow_cnt);
      end
      n_vec++;
      if (burst_req !== (c == 4)) begin
        n_err++; $display("FAIL reset_burst_req cycle %0d got %b want %b", c, burst_req, c == 4);
      end
      cyc();
    end
  endtask

  task automatic test_fifo_order();
    start_frame();
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1; s_data = 16'(i); cyc();
    end
    s_valid = 0; lcd_request = 1; first_ack = 1;
    for (int i = 1; i <= 16; i++) begin
      #1;
      n_vec++;
      if (lcd_data !== 16'(i) || lcd_data !== exp_lcd()) begin
        n_err++; $display("FAIL order_data %0d got %h want %h", i, lcd_data, 16'(i));
      end
      cyc();
    end
    lcd_request = 0;
    #1;
    n_vec++;
    if (fifo_level !== '0 || underflow !== 1'b0) begin
      n_err++; $display("FAIL order_drain level %0d uf %b want 0/0", fifo_level, underflow);
    end
    cyc();
  endtask

  task automatic test_fill();
    start_frame();
    s_valid = 1;
    for (int i = 0; i < DEPTH + 6; i++) begin
      s_data = 16'(i) + 16'h0100;
      #1;
      n_vec++;
      if (fifo_level !== (AW+1)'(mq.size()) || burst_req !== m_br || s_ready !== exp_ready()) begin
        n_err++; $display("FAIL fill step %0d level %0d br %b rdy %b want %0d/%b/%b",
                          i, fifo_level, burst_req, s_ready, mq.size(), m_br, exp_ready());
      end
      cyc();
    end
    s_valid = 0;
    #1;
    n_vec++;
    if (fifo_level !== 11'd1024 || s_ready !== 1'b0 || burst_req !== 1'b0) begin
      n_err++; $display("FAIL fill_full level %0d rdy %b br %b want 1024/0/0", fifo_level, s_ready, burst_req);
    end
    lcd_request = 1; first_ack = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_vec++;
      if (lcd_data !== 16'(i) + 16'h0100 || lcd_data !== exp_lcd()) begin
        n_err++; $display("FAIL fill_readback %0d got %h want %h", i, lcd_data, 16'(i) + 16'h0100);
      end
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_underflow();
    start_frame();
    lcd_request = 1; first_ack = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (lcd_data !== UF) begin n_err++; $display("FAIL uf_color %0d got %h want %h", i, lcd_data, UF); end
      cyc();
    end
    first_ack = 0;
    #1;
    n_vec++;
    if (underflow !== 1'b1 || underflow_cnt !== 16'd5) begin
      n_err++; $display("FAIL uf_count uf %b cnt %0d want 1/5", underflow, underflow_cnt);
    end
    n_vec++;
    if (lcd_data !== BG) begin n_err++; $display("FAIL uf_bg got %h want %h", lcd_data, BG); end
    cyc();
    #1;
    n_vec++;
    if (underflow_cnt !== 16'd5 || fifo_level !== '0) begin
      n_err++; $display("FAIL uf_outside cnt %0d level %0d want 5/0", underflow_cnt, fifo_level);
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_back_to_back();
    start_frame();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = 16'($urandom); cyc();
    end
    lcd_request = 1; first_ack = 1;
    for (int i = 0; i < 1100; i++) begin
      s_data = 16'($urandom);
      #1;
      n_vec++;
      if (fifo_level !== 11'd3 || lcd_data !== exp_lcd()) begin
        n_err++; $display("FAIL b2b step %0d level %0d data %h want 3/%h", i, fifo_level, lcd_data, exp_lcd());
      end
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_flush();
    start_frame();
    lcd_request = 1; first_ack = 1;
    repeat (7) cyc();
    lcd_request = 0;
    for (int i = 0; i < 500; i++) begin
      s_valid = 1; s_data = 16'($urandom); cyc();
    end
    s_valid = 0;
    lcd_vs = 0; cyc();
    lcd_vs = 1; cyc();
    s_valid = 1; s_data = 16'hBEEF;
    #1;
    n_vec++;
    if (frame_start !== 1'b1 || s_ready !== 1'b0) begin
      n_err++; $display("FAIL flush_cycle fs %b rdy %b want 1/0", frame_start, s_ready);
    end
    n_vec++;
    if (fifo_level !== 11'd500 || underflow_cnt !== 16'd7) begin
      n_err++; $display("FAIL flush_before level %0d cnt %0d want 500/7", fifo_level, underflow_cnt);
    end
    cyc();
    s_valid = 0;
    #1;
    n_vec++;
    if (fifo_level !== '0 || underflow !== 1'b0 || underflow_cnt !== 16'd0 || burst_req !== 1'b0) begin
      n_err++; $display("FAIL flush_after level %0d uf %b cnt %0d br %b want 0/0/0/0",
                        fifo_level, underflow, underflow_cnt, burst_req);
    end
    cyc();
    #1;
    n_vec++;
    if (burst_req !== 1'b1 || frame_start !== 1'b0) begin
      n_err++; $display("FAIL flush_resume br %b fs %b want 1/0", burst_req, frame_start);
    end
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      s_valid     = ($urandom_range(0, 99) < 55);
      s_data      = 16'($urandom);
      lcd_request = ($urandom_range(0, 99) < 70);
      first_ack   = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 149) == 0) lcd_vs = ~lcd_vs;
      #1;
      n_vec++;
      if (lcd_data !== exp_lcd() || s_ready !== exp_ready() || fifo_level !== (AW+1)'(mq.size())) begin
        n_err++; $display("FAIL rand_data step %0d data %h rdy %b level %0d want %h/%b/%0d",
                          i, lcd_data, s_ready, fifo_level, exp_lcd(), exp_ready(), mq.size());
      end
      n_vec++;
      if (frame_start !== m_fs || burst_req !== m_br || underflow !== m_uf || underflow_cnt !== m_ufc) begin
        n_err++; $display("FAIL rand_ctrl step %0d fs %b br %b uf %b cnt %0d want %b/%b/%b/%0d",
                          i, frame_start, burst_req, underflow, underflow_cnt, m_fs, m_br, m_uf, m_ufc);
      end
      cyc();
    end
    rst = 0;
  endtask

  initial begin
    mq.delete(); m_uf = 0; m_ufc = 0; m_fs = 0; m_vs_d = 0; m_br = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_fifo_order();
    test_fill();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
